code_lock_fsm: RTL and testbench

//  Push-button combination lock; the consumer of the debounced one-cycle press pulses.

---
 rtl/code_lock_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_code_lock_fsm.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_fsm.sv
// code_lock_fsm: push-button combination lock.
//
// Each one-cycle btn0/btn1 pulse enters one digit (btn0 = 0, btn1 = 1).
// Pulses on both buttons in the same cycle act as CLEAR. The first digit
// of an entry is compared with the MSB of CODE. A complete entry that
// matches CODE opens the lock for UNLOCK_CYCLES cycles. A wrong entry
// pulses err_pulse. MAX_FAIL consecutive wrong entries start a
// LOCKOUT_CYCLES lockout. All outputs are registered and go straight to
// the LEDs.
//
// Optional feature: define CODE_LOCK_TIMEOUT_EN to add an idle timer. If
// IDLE_TIMEOUT cycles pass with no press during an entry, the partial
// entry is dropped. That is not counted as a failure.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   btn0_pulse  in   one-cycle press pulse, digit 0
//   btn1_pulse  in   one-cycle press pulse, digit 1
//   unlocked    out  high while open
//   locked_out  out  high during lockout
//   err_pulse   out  one-cycle strobe on a wrong complete entry
//   digits      out  digits entered so far in the current entry
//   fail_count  out  consecutive wrong entries (saturates at MAX_FAIL)
module code_lock_fsm #(
    parameter int unsigned          CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0]  CODE           = 4'b0110,
    parameter int unsigned          MAX_FAIL       = 3,
    parameter int unsigned          UNLOCK_CYCLES  = 50000000,
    parameter int unsigned          LOCKOUT_CYCLES = 250000000,
    parameter int unsigned          IDLE_TIMEOUT   = 100000000
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              btn0_pulse,
    input  logic                              btn1_pulse,
    output logic                              unlocked,
    output logic                              locked_out,
    output logic                              err_pulse,
    output logic [$clog2(CODE_LEN+1)-1:0]     digits,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count
);

    localparam int unsigned DW = $clog2(CODE_LEN + 1);
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);
    localparam int unsigned UW = $clog2(UNLOCK_CYCLES + 1);
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StEntry, StOpen, StLockout} state_e;

    state_e              state_q, state_d;
    // Holds only the first CODE_LEN-1 digits; the last digit is taken
    // directly from the button on the edge that completes the entry.
    logic [CODE_LEN-2:0] shift_q, shift_d;
    logic [DW-1:0]       digits_q, digits_d;
    logic [FW-1:0]       fail_q, fail_d;
    logic [UW-1:0]       open_cnt_q, open_cnt_d;
    logic [LW-1:0]       lock_cnt_q, lock_cnt_d;
    logic                unlocked_q, unlocked_d;
    logic                locked_out_q, locked_out_d;
    logic                err_q, err_d;
    logic [CODE_LEN-1:0] entry_code;

    logic press;
    logic clear;
    assign press = btn0_pulse ^ btn1_pulse;
    assign clear = btn0_pulse & btn1_pulse;

`ifdef CODE_LOCK_TIMEOUT_EN
    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
`else
    logic unused_idle_timeout;
    assign unused_idle_timeout = ^IDLE_TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        digits_d   = digits_q;
        fail_d     = fail_q;
        open_cnt_d = open_cnt_q;
        lock_cnt_d = lock_cnt_q;
        err_d      = 1'b0;
        entry_code = {shift_q, btn1_pulse};
`ifdef CODE_LOCK_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (press) begin
                    shift_d  = entry_code[CODE_LEN-2:0];
                    digits_d = DW'(1);
                    state_d  = StEntry;
`ifdef CODE_LOCK_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            StEntry: begin
                if (clear) begin
                    state_d  = StIdle;
                    digits_d = '0;
                    shift_d  = '0;
                end else if (press) begin
`ifdef CODE_LOCK_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    if (digits_q == DW'(CODE_LEN - 1)) begin
                        digits_d = '0;
                        shift_d  = '0;
                        if (entry_code == CODE) begin
                            state_d    = StOpen;
                            fail_d     = '0;
                            open_cnt_d = '0;
                        end else begin
                            err_d = 1'b1;
                            if (fail_q != FW'(MAX_FAIL)) begin
                                fail_d = fail_q + FW'(1);
                            end
                            if (fail_d == FW'(MAX_FAIL)) begin
                                state_d    = StLockout;
                                lock_cnt_d = '0;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end else begin
                        shift_d  = entry_code[CODE_LEN-2:0];
                        digits_d = digits_q + DW'(1);
                    end
                end
`ifdef CODE_LOCK_TIMEOUT_EN
                else if (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)) begin
                    state_d    = StIdle;
                    digits_d   = '0;
                    shift_d    = '0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
`endif
            end
            StOpen: begin
                // The terminal count ends the window; the counter never wraps.
                if (clear || (open_cnt_q == UW'(UNLOCK_CYCLES - 1))) begin
                    state_d = StIdle;
                end else begin
                    open_cnt_d = open_cnt_q + UW'(1);
                end
            end
            StLockout: begin
                if (lock_cnt_q == LW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = StIdle;
                    fail_d  = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // Status LEDs follow the next state, so they change on the same edge.
        unlocked_d   = (state_d == StOpen);
        locked_out_d = (state_d == StLockout);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            digits_q     <= '0;
            fail_q       <= '0;
            open_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            digits_q     <= digits_d;
            fail_q       <= fail_d;
            open_cnt_q   <= open_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
            err_q        <= err_d;
        end
    end

`ifdef CODE_LOCK_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;
    assign err_pulse  = err_q;
    assign digits     = digits_q;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Testbench for code_lock_fsm.
// It runs directed scenarios and then random button traffic. Every check
// compares the DUT outputs with a behavioural model. The model keeps the
// entry as a queue of digits, the timed windows as cycles remaining, and
// the failure count as an integer.
module tb_code_lock_fsm;

    localparam int unsigned CL = 4;
    localparam logic [3:0]  CD = 4'b0110;
    localparam int unsigned MF = 3;
    localparam int unsigned UC = 8;
    localparam int unsigned LC = 16;
    localparam int unsigned IT = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       b0 = 1'b0;
    logic       b1 = 1'b0;
    logic       unlocked, locked_out, err_pulse;
    logic [2:0] digits;
    logic [1:0] fail_count;
    logic [7:0] obs;

    always #5 clk = ~clk;

    code_lock_fsm #(
        .CODE_LEN      (CL),
        .CODE          (CD),
        .MAX_FAIL      (MF),
        .UNLOCK_CYCLES (UC),
        .LOCKOUT_CYCLES(LC),
        .IDLE_TIMEOUT  (IT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn0_pulse(b0),
        .btn1_pulse(b1),
        .unlocked  (unlocked),
        .locked_out(locked_out),
        .err_pulse (err_pulse),
        .digits    (digits),
        .fail_count(fail_count)
    );

    assign obs = {unlocked, locked_out, err_pulse, digits, fail_count};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_open, m_lock, m_fail, m_idle;
    bit m_err;
    bit m_q[$];

    logic [1:0] stim[$];   // {btn1, btn0} per cycle

    task automatic model_reset();
        m_open = 0; m_lock = 0; m_fail = 0; m_idle = 0; m_err = 0;
        m_q.delete();
    endtask

    task automatic model_step(input logic p0, input logic p1);
        logic pr, clr;
        pr = p0 ^ p1;
        clr = p0 & p1;
        m_err = 0;
        if (m_open > 0) begin
            if (clr) m_open = 0;
            else m_open--;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fail = 0;
        end else if (clr) begin
            m_q.delete();
            m_idle = 0;
        end else if (pr) begin
            m_idle = 0;
            m_q.push_back(p1);
            if (m_q.size() == CL) begin
                int v = 0;
                foreach (m_q[i]) v = v * 2 + int'(m_q[i]);
                m_q.delete();
                if (v == int'(CD)) begin
                    m_open = UC;
                    m_fail = 0;
                end else begin
                    m_err = 1;
                    if (m_fail < MF) m_fail++;
                    if (m_fail == MF) m_lock = LC;
                end
            end
        end
`ifdef CODE_LOCK_TIMEOUT_EN
        else if (m_q.size() > 0) begin
            m_idle++;
            if (m_idle == IT) begin
                m_q.delete();
                m_idle = 0;
            end
        end
`endif
    endtask

    function automatic logic [7:0] exp_vec();
        return {m_open > 0, m_lock > 0, m_err, 3'(m_q.size()), 2'(m_fail)};
    endfunction

    task automatic cycle(input logic p0, input logic p1);
        b0 = p0;
        b1 = p1;
        @(posedge clk);
        model_step(p0, p1);
        #1;
        b0 = 1'b0;
        b1 = 1'b0;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) stim.push_back(2'b00);
    endtask

    task automatic add_code(input logic [3:0] code, input int gap);
        for (int i = 3; i >= 0; i--) begin
            stim.push_back(code[i] ? 2'b10 : 2'b01);
            add_idle(gap);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got {unl,lko,err,dig,fc}=%b want %b", obs, 8'h00);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_unlock();
        int ucnt = 0;
        add_code(4'b0110, 2);
        add_idle(12);
        foreach (stim[i]) begin
            cycle(stim[i][0], stim[i][1]);
            if (unlocked) ucnt++;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL unlock cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        stim.delete();
        n_checks++;
        if (ucnt != int'(UC)) begin
            n_fail++;
            $display("FAIL unlock_len: got %0d cycles want %0d", ucnt, UC);
        end
    endtask

    task automatic test_wrong_then_right();
        logic [1:0] fc_after_wrong = 2'bxx;
        add_code(4'b1111, 0);
        add_code(4'b0110, 1);
        add_idle(10);
        foreach (stim[i]) begin
            cycle(stim[i][0], stim[i][1]);
            if (i == 3) fc_after_wrong = fail_count;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrong_right cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        stim.delete();
        n_checks++;
        if (fc_after_wrong !== 2'd1) begin
            n_fail++;
            $display("FAIL wrong_fc: got %0d want 1", fc_after_wrong);
        end
    endtask

    task automatic test_lockout();
        int lcnt = 0;
        add_code(4'b1111, 0);
        add_code(4'b0000, 1);
        add_code(4'b1010, 0);
        add_code(4'b0110, 0);    // lands inside the lockout window
        add_idle(20);
        foreach (stim[i]) begin
            cycle(stim[i][0], stim[i][1]);
            if (locked_out) lcnt++;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL lockout cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        stim.delete();
        n_checks++;
        if (lcnt != int'(LC) || fail_count !== 2'd0 || unlocked !== 1'b0) begin
            n_fail++;
            $display("FAIL lockout_len: got %0d cycles fc=%0d unl=%b want %0d fc=0 unl=0",
                     lcnt, fail_count, unlocked, LC);
        end
    endtask

    task automatic test_clear();
        stim.push_back(2'b01);
        stim.push_back(2'b10);
        stim.push_back(2'b11);
        add_idle(2);
        add_code(4'b0110, 0);
        add_idle(3);
        stim.push_back(2'b11);   // relock while open
        add_idle(3);
        foreach (stim[i]) begin
            cycle(stim[i][0], stim[i][1]);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL clear cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        stim.delete();
    endtask

    task automatic test_timeout();
        logic seen_unl = 1'b0;
        logic want_unl;
`ifdef CODE_LOCK_TIMEOUT_EN
        want_unl = 1'b0;
`else
        want_unl = 1'b1;
`endif
        stim.push_back(2'b01);
        add_idle(40);
        stim.push_back(2'b10);
        stim.push_back(2'b10);
        stim.push_back(2'b01);
        add_idle(2);
        foreach (stim[i]) begin
            cycle(stim[i][0], stim[i][1]);
            if (unlocked) seen_unl = 1'b1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        stim.delete();
        n_checks++;
        if (seen_unl !== want_unl) begin
            n_fail++;
            $display("FAIL timeout_unlock: got %b want %b", seen_unl, want_unl);
        end
        add_idle(12);
        stim.push_back(2'b11);
        foreach (stim[i]) cycle(stim[i][0], stim[i][1]);
        stim.delete();
        model_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                stim.push_back(2'b01);
                stim.push_back(2'b10);
            end else begin
                add_code(4'b0110, 0);
                add_idle(2);
            end
            foreach (stim[i]) begin
                cycle(stim[i][0], stim[i][1]);
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL reset_mid ph %0d cyc %0d: got %b want %b",
                             ph, i, obs, exp_vec());
                end
            end
            stim.delete();
            reset_n = 1'b0;
            model_reset();
            #2;
            n_checks++;
            if (obs !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_async ph %0d: got %b want %b", ph, obs, 8'h00);
            end
            @(negedge clk);
            reset_n = 1'b1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 599) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #2;
                n_checks++;
                if (obs !== 8'h00) begin
                    n_fail++;
                    $display("FAIL random_reset cyc %0d: got %b want %b", i, obs, 8'h00);
                end
                @(negedge clk);
                reset_n = 1'b1;
            end
            if (r < 5) cycle(1'b1, 1'b1);
            else if (r < 50) begin
                logic d;
                d = 1'($urandom_range(0, 1));
                cycle(~d, d);
            end else cycle(1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_unlock();
        test_wrong_then_right();
        test_lockout();
        test_clear();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
